// File: rtl/mul_dot_ctrl.sv
// Issues operand pairs to a start/busy shift-add multiplier and accumulates
// N_TERMS products into a dot-product sum presented over valid/ready.
module mul_dot_ctrl #(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 2,
    parameter int ACC_W   = 18
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       op_a_bi,
    input  logic [7:0]       op_b_bi,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    output logic [7:0]       mul_a_bo,
    output logic [7:0]       mul_b_bo,
    output logic             mul_start_o,
    input  logic             mul_busy_i,
    input  logic [15:0]      mul_y_bi,
    output logic [ACC_W-1:0] sum_bo,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cnt;
    logic              last_term;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n     = rst_sync[1];
    assign acc_sum   = acc + ACC_W'(mul_y_bi);
    assign last_term = (cnt == CNT_W'(N_TERMS - 1));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        op_ready_o  = 1'b0;
        mul_start_o = 1'b0;
        sum_valid_o = 1'b0;
        busy_o      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    state_next = S_LAUNCH;
                end
            end
            // A core left running by a reset must finish before we may launch.
            S_LAUNCH: begin
                if (!mul_busy_i) begin
                    mul_start_o = 1'b1;
                    state_next  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (mul_busy_i) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!mul_busy_i) begin
                    state_next = last_term ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                sum_valid_o = 1'b1;
                if (sum_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The product is only valid in the cycle busy falls, so capture happens right there.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_bo <= '0;
            mul_b_bo <= '0;
            acc      <= '0;
            cnt      <= '0;
            sum_bo   <= '0;
        end else begin
            if (state == S_IDLE && op_valid_i) begin
                mul_a_bo <= op_a_bi;
                mul_b_bo <= op_b_bi;
            end
            if (state == S_WAIT_DONE && !mul_busy_i) begin
                if (last_term) begin
                    sum_bo <= acc_sum;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    acc    <= acc_sum;
                    cnt    <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_dot_ctrl.sv
// Directed bench for mul_dot_ctrl with a behavioural start/busy multiplier
// that takes eight busy cycles per product.
module tb_mul_dot_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic [7:0]  op_a_bi = '0;
    logic [7:0]  op_b_bi = '0;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [7:0]  mul_a_bo;
    logic [7:0]  mul_b_bo;
    logic        mul_start_o;
    logic        mul_busy_i;
    logic [15:0] mul_y_bi;
    logic [17:0] sum_bo;
    logic        sum_valid_o;
    logic        sum_ready_i = 1'b0;
    logic        busy_o;

    logic        m_busy = 1'b0;
    logic [15:0] m_y = '0;
    logic [3:0]  m_cnt = '0;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic        force_busy = 1'b0;
    int          start_count = 0;
    logic        prev_start = 1'b0;
    logic        double_start = 1'b0;

    int tests = 0;
    int failed = 0;

    mul_dot_ctrl #(.N_TERMS(4), .CNT_W(2), .ACC_W(18)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .op_a_bi     (op_a_bi),
        .op_b_bi     (op_b_bi),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .mul_a_bo    (mul_a_bo),
        .mul_b_bo    (mul_b_bo),
        .mul_start_o (mul_start_o),
        .mul_busy_i  (mul_busy_i),
        .mul_y_bi    (mul_y_bi),
        .sum_bo      (sum_bo),
        .sum_valid_o (sum_valid_o),
        .sum_ready_i (sum_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    assign mul_busy_i = m_busy | force_busy;
    assign mul_y_bi   = m_y;

    // Multiplier model: busy rises the edge after start, product valid when busy falls.
    always @(posedge clk_i) begin
        if (m_busy) begin
            if (m_cnt == 4'd1) begin
                m_busy <= 1'b0;
                m_y    <= 16'(m_a) * 16'(m_b);
            end
            m_cnt <= m_cnt - 4'd1;
        end else if (mul_start_o) begin
            m_busy <= 1'b1;
            m_cnt  <= 4'd8;
            m_a    <= mul_a_bo;
            m_b    <= mul_b_bo;
        end
    end

    always @(posedge clk_i) begin
        if (mul_start_o) begin
            start_count <= start_count + 1;
        end
        if (mul_start_o && prev_start) begin
            double_start <= 1'b1;
        end
        prev_start <= mul_start_o;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk_i);
        op_a_bi    = a;
        op_b_bi    = b;
        op_valid_i = 1'b1;
        while (!op_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check_output("accept_wait", {31'd0, op_ready_o}, 32'd1);
        @(posedge clk_i);
        #1 op_valid_i = 1'b0;
    endtask

    task automatic wait_sum(input logic [17:0] exp, input string tag, input logic ack);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!sum_valid_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check_output({tag, "_valid"}, {31'd0, sum_valid_o}, 32'd1);
        check_output({tag, "_sum"}, {14'd0, sum_bo}, {14'd0, exp});
        if (ack) begin
            sum_ready_i = 1'b1;
            @(posedge clk_i);
            #1 sum_ready_i = 1'b0;
            check_output({tag, "_drop"}, {31'd0, sum_valid_o}, 32'd0);
            check_output({tag, "_ready"}, {31'd0, op_ready_o}, 32'd1);
        end
    endtask

    initial begin
        int base;
        int n;

        // Reset values while reset is held
        #2 rst_n_i = 1'b0;
        #1;
        check_output("rst_op_ready", {31'd0, op_ready_o}, 32'd1);
        check_output("rst_sum_valid", {31'd0, sum_valid_o}, 32'd0);
        check_output("rst_start", {31'd0, mul_start_o}, 32'd0);
        check_output("rst_busy", {31'd0, busy_o}, 32'd0);
        check_output("rst_sum", {14'd0, sum_bo}, 32'd0);
        check_output("rst_mul_a", {24'd0, mul_a_bo}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // Dot product 15 + 200 + 65025 + 0
        base = start_count;
        apply_stimulus(8'd3, 8'd5);
        check_output("dot_mul_a", {24'd0, mul_a_bo}, 32'd3);
        check_output("dot_mul_b", {24'd0, mul_b_bo}, 32'd5);
        check_output("dot_busy", {31'd0, busy_o}, 32'd1);
        check_output("dot_not_ready", {31'd0, op_ready_o}, 32'd0);
        check_output("dot_start_lat", {31'd0, mul_start_o}, 32'd1);
        apply_stimulus(8'd10, 8'd20);
        apply_stimulus(8'd255, 8'd255);
        apply_stimulus(8'd0, 8'd7);
        wait_sum(18'd65240, "dot", 1'b1);
        check_output("dot_starts", 32'(start_count - base), 32'd4);

        // Maximum operands, no wrap at 18 bits
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'd255, 8'd255);
        end
        wait_sum(18'h3F804, "max", 1'b1);

        // Backpressure: 2 + 12 + 30 + 56, held for five cycles
        apply_stimulus(8'd1, 8'd2);
        apply_stimulus(8'd3, 8'd4);
        apply_stimulus(8'd5, 8'd6);
        apply_stimulus(8'd7, 8'd8);
        wait_sum(18'd100, "bp", 1'b0);
        op_a_bi    = 8'd99;
        op_b_bi    = 8'd98;
        op_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_output("bp_hold_sum", {14'd0, sum_bo}, 32'd100);
            check_output("bp_hold_valid", {31'd0, sum_valid_o}, 32'd1);
            check_output("bp_no_ready", {31'd0, op_ready_o}, 32'd0);
            check_output("bp_a_stable", {24'd0, mul_a_bo}, 32'd7);
            @(negedge clk_i);
        end
        op_valid_i  = 1'b0;
        sum_ready_i = 1'b1;
        @(posedge clk_i);
        #1 sum_ready_i = 1'b0;
        check_output("bp_accepted", {31'd0, sum_valid_o}, 32'd0);
        check_output("bp_a_unconsumed", {24'd0, mul_a_bo}, 32'd7);

        // Busy hold-off in LAUNCH: 6 + 1 + 1 + 1
        base = start_count;
        @(negedge clk_i);
        force_busy = 1'b1;
        apply_stimulus(8'd2, 8'd3);
        for (int i = 0; i < 3; i++) begin
            check_output("hold_no_start", {31'd0, mul_start_o}, 32'd0);
            @(negedge clk_i);
        end
        force_busy = 1'b0;
        #1;
        check_output("hold_start", {31'd0, mul_start_o}, 32'd1);
        @(posedge clk_i);
        #1;
        check_output("hold_one_pulse", {31'd0, mul_start_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(8'd1, 8'd1);
        end
        wait_sum(18'd9, "hold", 1'b1);
        check_output("hold_starts", 32'(start_count - base), 32'd4);

        // Reset during the third term's WAIT_DONE discards the partial sum
        apply_stimulus(8'd9, 8'd9);
        apply_stimulus(8'd9, 8'd9);
        apply_stimulus(8'd9, 8'd9);
        n = 0;
        while (!m_busy && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_output("mid_mul_busy", {31'd0, m_busy}, 32'd1);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        check_output("mid_rst_ready", {31'd0, op_ready_o}, 32'd1);
        check_output("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check_output("mid_rst_sum", {14'd0, sum_bo}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'd1, 8'd1);
        end
        wait_sum(18'd4, "post_rst", 1'b1);

        check_output("no_double_start", {31'd0, double_start}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
